// File: rtl/lcd1602_dyn_fields_ctrl.sv
// lcd1602_dyn_fields_ctrl: HD44780/LCD1602 8-bit write-only controller.
// Sends the init commands, then two static text lines from a writable 32x8
// text RAM, then refreshes NUM_FIELDS decimal numeric fields forever.
// LCD steps are paced by an internal tick. One step spans two ticks:
// at tick A, E rises with rs/data. At tick B, E falls.
module lcd1602_dyn_fields_ctrl #(
  parameter int unsigned             TICK_DIV   = 400000,
  parameter int unsigned             NUM_FIELDS = 2,
  parameter int unsigned             VALUE_W    = 8,
  parameter int unsigned             DIGITS     = 3,
  parameter logic [NUM_FIELDS*8-1:0] FIELD_POS  = 16'hC484,
  parameter bit                      LEAD_ZERO  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic [NUM_FIELDS*VALUE_W-1:0] field_val_i,
  input  logic                          txt_we_i,
  input  logic [4:0]                    txt_addr_i,
  input  logic [7:0]                    txt_data_i,
  output logic                          init_done_o,
  output logic                          rs,
  output logic                          rw,
  output logic                          enable,
  output logic [7:0]                    data
);

  localparam int unsigned CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BCD_RAW = (VALUE_W * 3) / 10 + 1;
  localparam int unsigned BCD_N   = (BCD_RAW > DIGITS) ? BCD_RAW : DIGITS;
  localparam int unsigned BCD_W   = 4 * BCD_N;
  localparam int unsigned DDC_W   = $clog2(VALUE_W + 1);
  localparam int unsigned FLD_W   = 3;
  localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_L1A  = 3'd2;
  localparam logic [2:0] S_L1   = 3'd3;
  localparam logic [2:0] S_L2A  = 3'd4;
  localparam logic [2:0] S_L2   = 3'd5;
  localparam logic [2:0] S_DYN  = 3'd6;

  logic [CNT_W-1:0]   tick_cnt_q;
  logic               tick;
  logic [2:0]         state_q, state_d;
  logic [4:0]         idx_q, idx_d;
  logic [FLD_W-1:0]   fld_q, fld_d;
  logic               phase_q, phase_d;
  logic               rs_q, rs_d, en_q, en_d;
  logic [7:0]         data_q, data_d;
  logic               init_done_q, init_done_d;
  logic               dirty_q, dirty_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [DDC_W-1:0]   ddc_q, ddc_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         ram_q [32];

  logic [VALUE_W-1:0] cur_val;
  logic [7:0]         cur_pos;
  logic [7:0]         dig_chr;
  logic               lead;
  logic               step_rs;
  logic [7:0]         step_data;
  logic               incl;
  logic [5:0]         sent;
  logic               dirty_set;

  assign tick = (tick_cnt_q == CNT_W'(TICK_DIV - 1));

  // Free-running tick divider.
  always_ff @(posedge clk) begin
    if (reset)     tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + CNT_W'(1);
  end

  // Text RAM: written in any state, keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (txt_we_i) ram_q[txt_addr_i] <= txt_data_i;
  end

  // Select the value and address command of the current field.
  always_comb begin
    cur_val = '0;
    cur_pos = 8'h00;
    for (int i = 0; i < int'(NUM_FIELDS); i++) begin
      if (fld_q == FLD_W'(i)) begin
        cur_val = field_val_i[i*VALUE_W +: VALUE_W];
        cur_pos = FIELD_POS[i*8 +: 8];
      end
    end
  end

  // Character for the current digit step; blanking walks down from the MSB.
  always_comb begin
    dig_chr = 8'h30;
    lead    = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      if (bcd_q[k*4 +: 4] != 4'd0) lead = 1'b0;
      if (idx_q == 5'(int'(DIGITS) - k)) begin
        if (ovf_q)                            dig_chr = 8'h23;
        else if (!LEAD_ZERO && lead && k != 0) dig_chr = 8'h20;
        else                                   dig_chr = 8'h30 + 8'(bcd_q[k*4 +: 4]);
      end
    end
  end

  // Double-dabble add-3 correction ahead of each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(BCD_N); k++) begin
      if (bcd_q[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
    end
  end

  // rs/data of the step that the current state and counters describe.
  always_comb begin
    step_rs   = 1'b0;
    step_data = 8'h00;
    case (state_q)
      S_INIT: begin
        case (idx_q[1:0])
          2'd0:    step_data = 8'h38;
          2'd1:    step_data = 8'h06;
          2'd2:    step_data = 8'h0C;
          default: step_data = 8'h01;
        endcase
      end
      S_L1A: step_data = 8'h80;
      S_L1: begin
        step_rs   = 1'b1;
        step_data = ram_q[{1'b0, idx_q[3:0]}];
      end
      S_L2A: step_data = 8'hC0;
      S_L2: begin
        step_rs   = 1'b1;
        step_data = ram_q[{1'b1, idx_q[3:0]}];
      end
      S_DYN: begin
        if (idx_q == 5'd0) begin
          step_data = cur_pos;
        end else begin
          step_rs   = 1'b1;
          step_data = dig_chr;
        end
      end
      default: ;
    endcase
  end

  // Number of text characters already latched for the display; a write
  // below this mark makes the shown text stale.
  always_comb begin
    incl = phase_q | tick;
    case (state_q)
      S_L1:    sent = 6'(idx_q) + 6'(incl);
      S_L2A:   sent = 6'd16;
      S_L2:    sent = 6'd16 + 6'(idx_q) + 6'(incl);
      S_DYN:   sent = 6'd32;
      default: sent = 6'd0;
    endcase
    dirty_set = txt_we_i && ({1'b0, txt_addr_i} < sent);
  end

  // Next-state logic: step output at tick A, sequencing at tick B.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fld_d       = fld_q;
    phase_d     = phase_q;
    rs_d        = rs_q;
    en_d        = en_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    dirty_d     = dirty_q | dirty_set;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    ddc_d       = ddc_q;
    ovf_d       = ovf_q;

    if (ddc_q != '0) begin
      {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
      ddc_d          = ddc_q - DDC_W'(1);
    end

    if (tick) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        if (state_q != S_IDLE) begin
          en_d   = 1'b1;
          rs_d   = step_rs;
          data_d = step_data;
        end
        if (state_q == S_DYN && idx_q == 5'd0) begin
          // Snapshot the value; first shift folds into the load.
          bcd_d = BCD_W'(cur_val[VALUE_W-1]);
          bin_d = cur_val << 1;
          ddc_d = DDC_W'(VALUE_W - 1);
          ovf_d = 32'(cur_val) > MAX_VAL;
        end
      end else begin
        en_d = 1'b0;
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              state_d = S_INIT;
              idx_d   = 5'd0;
            end
          end
          S_INIT: begin
            if (idx_q == 5'd3) begin
              state_d     = S_L1A;
              idx_d       = 5'd0;
              init_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
          S_L1A: begin
            state_d = S_L1;
            idx_d   = 5'd0;
          end
          S_L1: begin
            if (idx_q == 5'd15) begin
              state_d = S_L2A;
              idx_d   = 5'd0;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
          S_L2A: begin
            state_d = S_L2;
            idx_d   = 5'd0;
          end
          S_L2: begin
            if (idx_q == 5'd15) begin
              state_d = S_DYN;
              idx_d   = 5'd0;
              fld_d   = '0;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
          S_DYN: begin
            if (idx_q == 5'(DIGITS)) begin
              idx_d = 5'd0;
              if (dirty_q) begin
                state_d = S_L1A;
                fld_d   = '0;
                dirty_d = dirty_set;
              end else if (fld_q == FLD_W'(NUM_FIELDS - 1)) begin
                fld_d = '0;
              end else begin
                fld_d = fld_q + FLD_W'(1);
              end
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      fld_q       <= '0;
      phase_q     <= 1'b0;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
      dirty_q     <= 1'b0;
      bin_q       <= '0;
      bcd_q       <= '0;
      ddc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fld_q       <= fld_d;
      phase_q     <= phase_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      dirty_q     <= dirty_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      ddc_q       <= ddc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign init_done_o = init_done_q;
  assign rs          = rs_q;
  assign rw          = 1'b0;
  assign enable      = en_q;
  assign data        = data_q;

endmodule

// File: tb/tb_lcd1602_dyn_fields_ctrl.sv
// Bench for lcd1602_dyn_fields_ctrl. Instance A uses the default format.
// Instance B uses a 10-bit value with leading-zero blanking.
// Both instances share the text bus. Each falling E is captured with its rs/data
// and its high width. A queue of expected steps is compared against the captures.
module tb_lcd1602_dyn_fields_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a = 1'b1, reset_b = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] fv_a;
  logic [19:0] fv_b;
  logic        txt_we = 1'b0;
  logic [4:0]  txt_addr = 5'd0;
  logic [7:0]  txt_data = 8'h00;
  logic        done_a, rs_a, rw_a, enable_a;
  logic [7:0]  data_a;
  logic        done_b, rs_b, rw_b, enable_b;
  logic [7:0]  data_b;

  lcd1602_dyn_fields_ctrl #(.TICK_DIV(4)) u_dut_a (
    .clk(clk), .reset(reset_a), .start_i(start_a), .field_val_i(fv_a),
    .txt_we_i(txt_we), .txt_addr_i(txt_addr), .txt_data_i(txt_data),
    .init_done_o(done_a), .rs(rs_a), .rw(rw_a), .enable(enable_a), .data(data_a)
  );

  lcd1602_dyn_fields_ctrl #(.TICK_DIV(8), .VALUE_W(10), .LEAD_ZERO(1'b0)) u_dut_b (
    .clk(clk), .reset(reset_b), .start_i(start_b), .field_val_i(fv_b),
    .txt_we_i(txt_we), .txt_addr_i(txt_addr), .txt_data_i(txt_data),
    .init_done_o(done_b), .rs(rs_b), .rw(rw_b), .enable(enable_b), .data(data_b)
  );

  int          n_cmp = 0, n_bad = 0, n_step = 0;
  int          exp_w = 4;
  bit          sel_b = 1'b0;
  logic [7:0]  txt_m [32];
  logic [8:0]  exp_q [$];
  logic [16:0] obs_q [$];

  int   ha = 0, hb = 0;
  logic pa = 1'b0, pb = 1'b0;

  // Capture instance A steps at falling E.
  always @(negedge clk) begin
    if (reset_a) begin
      ha = 0; pa = 1'b0;
    end else begin
      if (enable_a) ha++;
      else if (pa) begin
        if (!sel_b) obs_q.push_back({8'(ha), rs_a, data_a});
        ha = 0;
      end
      pa = enable_a;
    end
  end

  // Capture instance B steps at falling E.
  always @(negedge clk) begin
    if (reset_b) begin
      hb = 0; pb = 1'b0;
    end else begin
      if (enable_b) hb++;
      else if (pb) begin
        if (sel_b) obs_q.push_back({8'(hb), rs_b, data_b});
        hb = 0;
      end
      pb = enable_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic r, input logic [7:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic push_init();
    push(1'b0, 8'h38); push(1'b0, 8'h06); push(1'b0, 8'h0C); push(1'b0, 8'h01);
  endtask

  task automatic push_lines();
    push(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) push(1'b1, txt_m[i]);
    push(1'b0, 8'hC0);
    for (int i = 16; i < 32; i++) push(1'b1, txt_m[i]);
  endtask

  // Reference digit k (0 = hundreds) of a 3-digit field.
  function automatic logic [7:0] dig_m(input int v, input int k, input bit lz);
    int p;
    p = (k == 0) ? 100 : (k == 1) ? 10 : 1;
    if (v > 999) return 8'h23;
    if (!lz && k < 2 && v < p) return 8'h20;
    return 8'(8'h30 + (v / p) % 10);
  endfunction

  task automatic push_field(input logic [7:0] pos, input int v, input bit lz);
    push(1'b0, pos);
    for (int k = 0; k < 3; k++) push(1'b1, dig_m(v, k, lz));
  endtask

  // Pop expected steps against captured ones, with a cycle budget per step.
  task automatic drain();
    logic [16:0] o;
    logic [8:0]  e;
    int          t;
    while (exp_q.size() > 0) begin
      t = 0;
      while (obs_q.size() == 0 && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (obs_q.size() == 0) begin
        check("step_timeout", obs_q.size(), 1);
        exp_q.delete();
        return;
      end
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_step++;
      check($sformatf("step%0d", n_step), 32'(o[8:0]), 32'(e));
      check($sformatf("ewidth%0d", n_step), 32'(o[16:9]), exp_w);
    end
  endtask

  task automatic txt_write(input int a, input logic [7:0] d);
    @(negedge clk);
    txt_we   = 1'b1;
    txt_addr = 5'(a);
    txt_data = d;
    txt_m[a] = d;
    @(negedge clk);
    txt_we   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    fv_a = {8'd5, 8'd207};
    fv_b = {10'd0, 10'd1000};
    repeat (3) @(negedge clk);
    check("rst_rs", rs_a, 0);
    check("rst_rw", rw_a, 0);
    check("rst_en", enable_a, 0);
    check("rst_data", data_a, 0);
    check("rst_done", done_a, 0);
    reset_a = 1'b0;

    for (int i = 0; i < 32; i++) txt_write(i, 8'(8'h41 + i));
    check("idle_no_e", obs_q.size(), 0);

    start_a = 1'b1;
    push_init();
    drain();
    check("init_done", done_a, 1);

    push_lines();
    push_field(8'h84, 207, 1'b1); push_field(8'hC4, 5, 1'b1);
    push_field(8'h84, 207, 1'b1); push_field(8'hC4, 5, 1'b1);
    drain();

    // Value change between the first and second digit of field0.
    push(1'b0, 8'h84); push(1'b1, 8'h32);
    drain();
    fv_a[7:0] = 8'd33;
    push(1'b1, 8'h30); push(1'b1, 8'h37);
    push_field(8'hC4, 5, 1'b1); push_field(8'h84, 33, 1'b1); push_field(8'hC4, 5, 1'b1);
    push(1'b0, 8'h84);
    drain();

    // Text write during field0 digits forces a rewrite after the field.
    txt_write(20, 8'h58);
    push(1'b1, 8'h30); push(1'b1, 8'h33); push(1'b1, 8'h33);
    push_lines();
    push_field(8'h84, 33, 1'b1);
    drain();

    // Reset in the middle of a step.
    t = 0;
    while (!enable_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("e_rise", enable_a, 1);
    reset_a = 1'b1;
    @(negedge clk);
    check("mid_rst_en", enable_a, 0);
    check("mid_rst_rs", rs_a, 0);
    check("mid_rst_data", data_a, 0);
    check("mid_rst_done", done_a, 0);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    reset_a = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_after_rst", obs_q.size(), 0);
    check("idle_en", enable_a, 0);

    // Instance B: overflow, blanking, 999.
    sel_b = 1'b1;
    exp_w = 8;
    reset_b = 1'b0;
    @(negedge clk);
    start_b = 1'b1;
    push_init();
    push_lines();
    push_field(8'h84, 1000, 1'b0); push_field(8'hC4, 0, 1'b0);
    drain();
    fv_b[9:0] = 10'd999;
    push_field(8'h84, 999, 1'b0); push_field(8'hC4, 0, 1'b0);
    drain();
    check("b_done", done_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
